// File: rtl/wb_sram_bridge.sv
// rtl/wb_sram_bridge.sv - Wishbone classic slave bridging a 4 KiB window onto two single-port SRAM banks
//
// Ports:
//   clk_i, rst_i             clock, synchronous active-high reset
//   wbs_cyc_i/stb_i/we_i     Wishbone cycle, strobe, write enable
//   wbs_sel_i, wbs_adr_i     byte lanes, byte address
//   wbs_dat_i, wbs_dat_o     write data in, read data out (zero unless acking)
//   wbs_ack_o                single-cycle acknowledge
//   o_csb0/o_web0/o_wmask0/o_waddr0/o_din0, i_dout0           bank 0 SRAM pins
//   o_csb0_1/o_web0_1/o_wmask0_1/o_waddr0_1/o_din0_1, i_dout0_1  bank 1 SRAM pins
module wb_sram_bridge #(
  parameter logic [31:0] BASE_ADDR = 32'h3000_0000,
  parameter int          ADDR_W    = 9,
  parameter logic [31:0] ERR_DATA  = 32'h0000_0000
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              wbs_cyc_i,
  input  logic              wbs_stb_i,
  input  logic              wbs_we_i,
  input  logic [3:0]        wbs_sel_i,
  input  logic [31:0]       wbs_adr_i,
  input  logic [31:0]       wbs_dat_i,
  output logic              wbs_ack_o,
  output logic [31:0]       wbs_dat_o,
  output logic              o_csb0,
  output logic              o_web0,
  output logic [3:0]        o_wmask0,
  output logic [ADDR_W-1:0] o_waddr0,
  output logic [31:0]       o_din0,
  input  logic [31:0]       i_dout0,
  output logic              o_csb0_1,
  output logic              o_web0_1,
  output logic [3:0]        o_wmask0_1,
  output logic [ADDR_W-1:0] o_waddr0_1,
  output logic [31:0]       o_din0_1,
  input  logic [31:0]       i_dout0_1
);

  typedef enum logic [1:0] {IDLE, CMD, RWAIT, ACK} state_t;

  state_t state;
  logic   we_q;
  logic   bank_q;
  logic   skip_q;   // blocks acceptance in the cycle right after an ack

  logic              hit;
  logic              req_bank;
  logic [ADDR_W-1:0] req_word;
  logic [3:0]        req_mask;
  logic              unused_adr;

  assign hit        = (wbs_adr_i[31:12] == BASE_ADDR[31:12]);
  assign req_bank   = wbs_adr_i[11];
  assign req_word   = wbs_adr_i[2 +: ADDR_W];
  assign req_mask   = wbs_we_i ? wbs_sel_i : 4'hF;
  assign unused_adr = ^wbs_adr_i[1:0];

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state      <= IDLE;
      we_q       <= 1'b0;
      bank_q     <= 1'b0;
      skip_q     <= 1'b0;
      wbs_ack_o  <= 1'b0;
      wbs_dat_o  <= 32'h0;
      o_csb0     <= 1'b1;
      o_web0     <= 1'b1;
      o_wmask0   <= 4'h0;
      o_waddr0   <= '0;
      o_din0     <= 32'h0;
      o_csb0_1   <= 1'b1;
      o_web0_1   <= 1'b1;
      o_wmask0_1 <= 4'h0;
      o_waddr0_1 <= '0;
      o_din0_1   <= 32'h0;
    end else begin
      // SRAM strobes are only active for the single CMD cycle; address and
      // data hold so the macro inputs do not toggle needlessly.
      o_csb0     <= 1'b1;
      o_web0     <= 1'b1;
      o_wmask0   <= 4'h0;
      o_csb0_1   <= 1'b1;
      o_web0_1   <= 1'b1;
      o_wmask0_1 <= 4'h0;
      wbs_ack_o  <= 1'b0;
      wbs_dat_o  <= 32'h0;

      case (state)
        IDLE: begin
          if (skip_q) begin
            skip_q <= 1'b0;
          end else if (wbs_cyc_i && wbs_stb_i) begin
            if (hit) begin
              we_q   <= wbs_we_i;
              bank_q <= req_bank;
              state  <= CMD;
              if (!req_bank) begin
                o_csb0   <= 1'b0;
                o_web0   <= ~wbs_we_i;
                o_wmask0 <= req_mask;
                o_waddr0 <= req_word;
                o_din0   <= wbs_dat_i;
              end else begin
                o_csb0_1   <= 1'b0;
                o_web0_1   <= ~wbs_we_i;
                o_wmask0_1 <= req_mask;
                o_waddr0_1 <= req_word;
                o_din0_1   <= wbs_dat_i;
              end
            end else begin
              // Out-of-window: ack immediately, drop writes, return ERR_DATA on reads.
              wbs_ack_o <= 1'b1;
              wbs_dat_o <= wbs_we_i ? 32'h0 : ERR_DATA;
              state     <= ACK;
            end
          end
        end

        CMD: begin
          // The SRAM command has already been issued; an abort only suppresses the ack.
          if (!wbs_cyc_i) begin
            state <= IDLE;
          end else if (we_q) begin
            wbs_ack_o <= 1'b1;
            state     <= ACK;
          end else begin
            state <= RWAIT;
          end
        end

        RWAIT: begin
          if (!wbs_cyc_i) begin
            state <= IDLE;
          end else begin
            wbs_ack_o <= 1'b1;
            wbs_dat_o <= bank_q ? i_dout0_1 : i_dout0;
            state     <= ACK;
          end
        end

        ACK: begin
          state  <= IDLE;
          skip_q <= 1'b1;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_wb_sram_bridge.sv
// tb/tb_wb_sram_bridge.sv - randomized self-checking bench for wb_sram_bridge
module tb_wb_sram_bridge;

  localparam logic [31:0] BASE = 32'h3000_0000;
  localparam logic [31:0] ERR  = 32'hDEAD_0BAD;
  localparam int          MAXC = 8192;

  localparam int F_ACK  = 0;
  localparam int F_DAT  = 1;
  localparam int F_CSB0 = 2;
  localparam int F_CSB1 = 3;
  localparam int F_WEB0 = 4;
  localparam int F_WEB1 = 5;
  localparam int F_WA0  = 6;
  localparam int F_WA1  = 7;
  localparam int F_WM0  = 8;
  localparam int F_DIN0 = 9;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_i;
  logic        cyc, stb, we;
  logic [3:0]  sel;
  logic [31:0] adr, wdat;
  logic        ack;
  logic [31:0] rdat;
  logic        csb0, csb1, web0, web1;
  logic [3:0]  wm0, wm1;
  logic [8:0]  wa0, wa1;
  logic [31:0] din0, din1, dout0, dout1;

  wb_sram_bridge #(
    .BASE_ADDR (BASE),
    .ADDR_W    (9),
    .ERR_DATA  (ERR)
  ) dut (
    .clk_i      (clk),
    .rst_i      (rst_i),
    .wbs_cyc_i  (cyc),
    .wbs_stb_i  (stb),
    .wbs_we_i   (we),
    .wbs_sel_i  (sel),
    .wbs_adr_i  (adr),
    .wbs_dat_i  (wdat),
    .wbs_ack_o  (ack),
    .wbs_dat_o  (rdat),
    .o_csb0     (csb0),
    .o_web0     (web0),
    .o_wmask0   (wm0),
    .o_waddr0   (wa0),
    .o_din0     (din0),
    .i_dout0    (dout0),
    .o_csb0_1   (csb1),
    .o_web0_1   (web1),
    .o_wmask0_1 (wm1),
    .o_waddr0_1 (wa1),
    .o_din0_1   (din1),
    .i_dout0_1  (dout1)
  );

  // Reference memory contents, updated at transaction level by the driver.
  logic [31:0] ref_mem [2][512];

  // SRAM macro models driven purely by the DUT pins.
  logic [31:0] sram0 [512];
  logic [31:0] sram1 [512];
  bit          load_mem = 1'b0;

  always @(posedge clk) begin
    if (load_mem)
      for (int i = 0; i < 512; i++) begin
        sram0[i] <= ref_mem[0][i];
        sram1[i] <= ref_mem[1][i];
      end
    if (!csb0) begin
      if (!web0) begin
        for (int b = 0; b < 4; b++)
          if (wm0[b]) sram0[wa0][8*b +: 8] <= din0[8*b +: 8];
      end else begin
        dout0 <= sram0[wa0];
      end
    end
    if (!csb1) begin
      if (!web1) begin
        for (int b = 0; b < 4; b++)
          if (wm1[b]) sram1[wa1][8*b +: 8] <= din1[8*b +: 8];
      end else begin
        dout1 <= sram1[wa1];
      end
    end
  end

  int cycle = 0;
  always @(posedge clk) cycle <= cycle + 1;

  // Per-cycle expectations; all-zero entries mean "bus idle, SRAMs deselected".
  bit        e_ack  [MAXC];
  bit [31:0] e_dat  [MAXC];
  bit        e_cmd  [MAXC];
  bit        e_bank [MAXC];
  bit        e_web  [MAXC];
  bit [3:0]  e_wm   [MAXC];
  bit [8:0]  e_addr [MAXC];
  bit [31:0] e_din  [MAXC];

  typedef struct {
    int        c;
    int        f;
    bit [31:0] v;
    string     name;
  } pin_t;
  pin_t pins[$];

  int n_checks = 0;
  int n_err    = 0;
  bit check_en = 1'b0;
  bit sel0, sel1;

  function automatic logic [31:0] obs(input int f);
    case (f)
      F_ACK:   return 32'(ack);
      F_DAT:   return rdat;
      F_CSB0:  return 32'(csb0);
      F_CSB1:  return 32'(csb1);
      F_WEB0:  return 32'(web0);
      F_WEB1:  return 32'(web1);
      F_WA0:   return 32'(wa0);
      F_WA1:   return 32'(wa1);
      F_WM0:   return 32'(wm0);
      F_DIN0:  return din0;
      default: return 32'hFFFF_FFFF;
    endcase
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s cycle %0d: got 0x%08h expected 0x%08h", name, cycle, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (check_en && cycle < MAXC) begin
      sel0 = e_cmd[cycle] && !e_bank[cycle];
      sel1 = e_cmd[cycle] &&  e_bank[cycle];
      chk("ack",    32'(ack),  32'(e_ack[cycle]));
      chk("dat",    rdat,      e_dat[cycle]);
      chk("csb0",   32'(csb0), 32'(!sel0));
      chk("csb1",   32'(csb1), 32'(!sel1));
      chk("web0",   32'(web0), 32'(sel0 ? e_web[cycle] : 1'b1));
      chk("web1",   32'(web1), 32'(sel1 ? e_web[cycle] : 1'b1));
      chk("wmask0", 32'(wm0),  32'(sel0 ? e_wm[cycle] : 4'h0));
      chk("wmask1", 32'(wm1),  32'(sel1 ? e_wm[cycle] : 4'h0));
      if (sel0) begin
        chk("addr0", 32'(wa0), 32'(e_addr[cycle]));
        chk("din0",  din0,     e_din[cycle]);
      end
      if (sel1) begin
        chk("addr1", 32'(wa1), 32'(e_addr[cycle]));
        chk("din1",  din1,     e_din[cycle]);
      end
      foreach (pins[i])
        if (pins[i].c == cycle) chk(pins[i].name, obs(pins[i].f), pins[i].v);
    end
  end

  bit prev_acked = 1'b0;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic bus_idle();
    cyc  = 1'b0;
    stb  = 1'b0;
    we   = 1'($urandom_range(0, 1));
    sel  = 4'($urandom);
    adr  = $urandom;
    wdat = $urandom;
  endtask

  task automatic drive(input bit w, input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    cyc  = 1'b1;
    stb  = 1'b1;
    we   = w;
    adr  = a;
    wdat = d;
    sel  = s;
  endtask

  task automatic pin(input int c, input int f, input logic [31:0] v, input string name);
    pin_t p;
    p.c = c; p.f = f; p.v = v; p.name = name;
    pins.push_back(p);
  endtask

  // Let the post-ack dead cycle pass so the next request is accepted at once.
  task automatic settle();
    if (prev_acked) begin
      bus_idle();
      step();
      prev_acked = 1'b0;
    end
  endtask

  // One master transaction; abort: 0 none, 1 drop cyc in CMD, 2 drop cyc in RWAIT.
  task automatic txn(input bit w, input logic [31:0] a, input logic [31:0] d,
                     input logic [3:0] s, input int abort, output int c0);
    bit       hit, bank;
    bit [8:0] word;
    if (prev_acked) begin
      // The cycle after an ack is ignored by the slave; sometimes keep the strobe up through it.
      if ($urandom_range(0, 1) == 1) drive(w, a, d, s);
      else bus_idle();
      step();
    end
    drive(w, a, d, s);
    c0 = cycle;
    if (c0 + 5 >= MAXC) begin
      $display("FAIL cycle_budget: got %0d expected < %0d", c0, MAXC - 5);
      $fatal(1, "cycle budget exhausted");
    end
    hit  = (a[31:12] == BASE[31:12]);
    bank = a[11];
    word = a[10:2];
    if (hit) begin
      e_cmd[c0+1]  = 1'b1;
      e_bank[c0+1] = bank;
      e_web[c0+1]  = !w;
      e_wm[c0+1]   = w ? s : 4'hF;
      e_addr[c0+1] = word;
      e_din[c0+1]  = d;
      if (w)
        for (int b = 0; b < 4; b++)
          if (s[b]) ref_mem[bank][word][8*b +: 8] = d[8*b +: 8];
      if (abort == 0) begin
        if (w) begin
          e_ack[c0+2] = 1'b1;
          repeat (2) step();
        end else begin
          e_ack[c0+3] = 1'b1;
          e_dat[c0+3] = ref_mem[bank][word];
          repeat (3) step();
        end
        step();
        bus_idle();
        prev_acked = 1'b1;
      end else begin
        repeat (abort) step();
        bus_idle();
        step();
        prev_acked = 1'b0;
      end
    end else begin
      e_ack[c0+1] = 1'b1;
      e_dat[c0+1] = w ? 32'h0 : ERR;
      repeat (2) step();
      bus_idle();
      prev_acked = 1'b1;
    end
  endtask

  int c, cc;

  initial begin
    rst_i = 1'b1;
    bus_idle();
    for (int b = 0; b < 2; b++)
      for (int i = 0; i < 512; i++) ref_mem[b][i] = $urandom;
    load_mem = 1'b1;
    step();
    load_mem = 1'b0;
    step();
    step();

    // Reset state
    c = cycle;
    pin(c, F_CSB0, 32'd1, "rst_csb0");
    pin(c, F_CSB1, 32'd1, "rst_csb1");
    pin(c, F_ACK,  32'd0, "rst_ack");
    pin(c, F_DAT,  32'd0, "rst_dat");
    pin(c, F_WA0,  32'd0, "rst_addr0");
    pin(c, F_DIN0, 32'd0, "rst_din0");
    pin(c, F_WM0,  32'd0, "rst_wmask0");
    check_en = 1'b1;
    rst_i    = 1'b0;
    step();

    // Full-word write to bank 0, word 4
    settle(); c = cycle;
    pin(c+1, F_CSB0, 32'd0, "wr_csb0");
    pin(c+1, F_WEB0, 32'd0, "wr_web0");
    pin(c+1, F_WA0,  32'd4, "wr_addr0");
    pin(c+1, F_WM0,  32'hF, "wr_wmask0");
    pin(c+1, F_DIN0, 32'hA5A5_1234, "wr_din0");
    pin(c+1, F_CSB1, 32'd1, "wr_csb1_idle");
    pin(c+1, F_ACK,  32'd0, "wr_ack_early");
    pin(c+2, F_ACK,  32'd1, "wr_ack");
    txn(1'b1, 32'h3000_0010, 32'hA5A5_1234, 4'hF, 0, cc);

    // Bank 1 read of a known word
    settle();
    txn(1'b1, 32'h3000_0810, 32'h1122_3344, 4'hF, 0, cc);
    settle(); c = cycle;
    pin(c+1, F_CSB1, 32'd0, "rd_csb1");
    pin(c+1, F_WEB1, 32'd1, "rd_web1");
    pin(c+1, F_WA1,  32'd4, "rd_addr1");
    pin(c+1, F_CSB0, 32'd1, "rd_csb0_idle");
    pin(c+2, F_ACK,  32'd0, "rd_ack_early");
    pin(c+3, F_ACK,  32'd1, "rd_ack");
    pin(c+3, F_DAT,  32'h1122_3344, "rd_dat");
    txn(1'b0, 32'h3000_0810, 32'h0, 4'hF, 0, cc);

    // Single-byte write then readback
    settle();
    txn(1'b1, 32'h3000_0020, 32'h1111_1111, 4'hF, 0, cc);
    settle(); c = cycle;
    pin(c+1, F_WM0, 32'h4, "byte_wmask0");
    txn(1'b1, 32'h3000_0020, 32'hDEAD_BEEF, 4'b0100, 0, cc);
    settle(); c = cycle;
    pin(c+3, F_DAT, 32'h11AD_1111, "byte_readback");
    txn(1'b0, 32'h3000_0022, 32'h0, 4'h0, 0, cc);

    // sel=0 write leaves memory untouched
    settle();
    txn(1'b1, 32'h3000_0010, 32'hFFFF_FFFF, 4'h0, 0, cc);
    settle(); c = cycle;
    pin(c+3, F_DAT, 32'hA5A5_1234, "sel0_readback");
    txn(1'b0, 32'h3000_0010, 32'h0, 4'hF, 0, cc);

    // Out-of-window accesses
    settle(); c = cycle;
    pin(c+1, F_ACK,  32'd1, "miss_rd_ack");
    pin(c+1, F_DAT,  ERR,   "miss_rd_dat");
    pin(c+1, F_CSB0, 32'd1, "miss_csb0");
    pin(c+1, F_CSB1, 32'd1, "miss_csb1");
    txn(1'b0, 32'h3000_1000, 32'h0, 4'hF, 0, cc);
    settle(); c = cycle;
    pin(c+1, F_ACK, 32'd1, "miss_wr_ack");
    pin(c+1, F_DAT, 32'd0, "miss_wr_dat");
    txn(1'b1, 32'h2FFF_FFFC, 32'h5555_AAAA, 4'hF, 0, cc);

    // Abort in RWAIT, then a normal read
    settle(); c = cycle;
    pin(c+1, F_CSB0, 32'd1 - 32'd1, "abort_csb0");
    pin(c+3, F_ACK,  32'd0, "abort_no_ack");
    txn(1'b0, 32'h3000_0004, 32'h0, 4'hF, 2, cc);
    c = cycle;
    pin(c+2, F_ACK, 32'd0, "post_abort_early");
    pin(c+3, F_ACK, 32'd1, "post_abort_ack");
    txn(1'b0, 32'h3000_0000, 32'h0, 4'hF, 0, cc);

    // Reset for two cycles while a read sits in CMD
    settle(); c = cycle;
    drive(1'b0, 32'h3000_0814, 32'h1357_9BDF, 4'h3);
    e_cmd[c+1]  = 1'b1;
    e_bank[c+1] = 1'b1;
    e_web[c+1]  = 1'b1;
    e_wm[c+1]   = 4'hF;
    e_addr[c+1] = 9'd5;
    e_din[c+1]  = 32'h1357_9BDF;
    pin(c+2, F_CSB0, 32'd1, "midrst_csb0");
    pin(c+2, F_CSB1, 32'd1, "midrst_csb1");
    pin(c+2, F_ACK,  32'd0, "midrst_ack");
    pin(c+2, F_DAT,  32'd0, "midrst_dat");
    pin(c+3, F_ACK,  32'd0, "midrst_no_ack");
    step();
    rst_i = 1'b1;
    step();
    step();
    rst_i = 1'b0;
    bus_idle();
    step();
    prev_acked = 1'b0;

    // Randomized traffic
    for (int n = 0; n < 300; n++) begin
      bit          w;
      bit          h;
      logic [31:0] a;
      int          ab;
      int          gap;
      w   = 1'($urandom_range(0, 1));
      h   = ($urandom_range(0, 3) != 0);
      gap = $urandom_range(0, 3);
      if (h) begin
        a  = BASE | (32'($urandom_range(0, 1)) << 11)
                  | (32'($urandom_range(0, 15)) << 2) | 32'($urandom_range(0, 3));
        if ($urandom_range(0, 7) == 0) a[10:2] = 9'($urandom);
        ab = ($urandom_range(0, 9) == 0) ? (w ? 1 : $urandom_range(1, 2)) : 0;
      end else begin
        a = $urandom;
        if (a[31:12] == BASE[31:12]) a[31] = ~a[31];
        ab = 0;
      end
      if (gap > 0) begin
        bus_idle();
        repeat (gap) step();
        prev_acked = 1'b0;
      end
      txn(w, a, $urandom, 4'($urandom), ab, cc);
    end

    settle();
    repeat (3) step();
    check_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
